// File: rtl/apb_pkg.sv
// Shared types and constants for the APB register-file completer.
package apb_pkg;

  localparam int APB_ADDR_W = 5;
  localparam int APB_DATA_W = 32;

  localparam logic [APB_ADDR_W-1:0] APB_ID_ADDR  = 5'h1F;
  localparam logic [APB_DATA_W-1:0] APB_ID_VALUE = 32'hA9B0_0001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_slave_regfile_if.sv
// APB requester/completer signal bundle.
interface apb_slave_regfile_if #(
    parameter int ADDR_W = apb_pkg::APB_ADDR_W,
    parameter int DATA_W = apb_pkg::APB_DATA_W
);

    // Handshake: a transfer is one SETUP cycle (psel=1, penable=0) followed by
    // ACCESS cycles (psel=1, penable=1); it completes on the clock edge that
    // samples psel=1 with pready=1, and pslverr/prdata are meaningful only then.
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_regfile_mem.sv
// NUM_REGS x DATA_W register array: one write port, one combinational read port.
module apb_regfile_mem #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [DATA_W-1:0] mem [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (int'(waddr) < NUM_REGS)) begin
            mem[waddr[IDX_W-1:0]] <= wdata;
        end
    end

    // Out-of-range reads return zero so no index ever leaves the array.
    assign rdata = (int'(raddr) < NUM_REGS) ? mem[raddr[IDX_W-1:0]] : '0;

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer: programmable wait states, RW register file, read-only ID word.
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int              ADDR_W      = APB_ADDR_W,
    parameter int              DATA_W      = APB_DATA_W,
    parameter int              NUM_REGS    = 16,
    parameter int              WAIT_CYCLES = 1,
    parameter logic [DATA_W-1:0] ID_VALUE  = APB_ID_VALUE
) (
    input  logic                clk,
    input  logic                rst_n,
    apb_slave_regfile_if.slave  bus,
    output apb_state_e          dbg_state
);

    localparam int                CNT_W   = 4;
    localparam logic [ADDR_W-1:0] ID_ADDR = '1;

    apb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] prdata_q, prdata_d;
    logic              pready_q, pready_d;
    logic              pslverr_q, pslverr_d;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_we;
    logic              in_range;
    logic              setup;

    assign in_range = int'(bus.paddr) < NUM_REGS;
    assign setup    = bus.psel && !bus.penable;

    apb_regfile_mem #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (mem_we),
        .waddr (bus.paddr),
        .wdata (bus.pwdata),
        .raddr (bus.paddr),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prdata_d  = prdata_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        mem_we    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (setup) begin
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!bus.psel) begin
                    state_d = IDLE;
                end else if (bus.penable) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        // Commit edge: address and data are taken only here.
                        state_d  = RESP;
                        pready_d = 1'b1;
                        if (in_range) begin
                            mem_we = bus.pwrite;
                            if (!bus.pwrite) prdata_d = mem_rdata;
                        end else if ((bus.paddr == ID_ADDR) && !bus.pwrite) begin
                            prdata_d = ID_VALUE;
                        end else begin
                            prdata_d  = '0;
                            pslverr_d = 1'b1;
                        end
                    end
                end
            end
            RESP: begin
                if (setup) begin
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    state_d = WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
        end
    end

    assign bus.prdata  = prdata_q;
    assign bus.pready  = pready_q;
    assign bus.pslverr = pslverr_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: three completers (0, 1, 7 wait states) on one requester.
module tb_apb_slave_regfile;
    import apb_pkg::*;

    localparam int NR = 16;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // ---------------- requester signals ----------------
    logic        psel    = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite  = 1'b0;
    logic [4:0]  paddr   = '0;
    logic [31:0] pwdata  = '0;
    int          act     = 0;

    apb_slave_regfile_if if0 ();
    apb_slave_regfile_if if1 ();
    apb_slave_regfile_if if2 ();

    assign if0.psel = psel && (act == 0);
    assign if1.psel = psel && (act == 1);
    assign if2.psel = psel && (act == 2);
    assign if0.penable = penable;  assign if1.penable = penable;  assign if2.penable = penable;
    assign if0.pwrite  = pwrite;   assign if1.pwrite  = pwrite;   assign if2.pwrite  = pwrite;
    assign if0.paddr   = paddr;    assign if1.paddr   = paddr;    assign if2.paddr   = paddr;
    assign if0.pwdata  = pwdata;   assign if1.pwdata  = pwdata;   assign if2.pwdata  = pwdata;

    apb_state_e dbg [3];

    apb_slave_regfile #(.NUM_REGS(NR), .WAIT_CYCLES(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0), .dbg_state(dbg[0]));
    apb_slave_regfile #(.NUM_REGS(NR), .WAIT_CYCLES(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1), .dbg_state(dbg[1]));
    apb_slave_regfile #(.NUM_REGS(NR), .WAIT_CYCLES(7)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2), .dbg_state(dbg[2]));

    logic [31:0] prd [3];
    logic        rdy [3];
    logic        err [3];
    logic        sel [3];
    assign prd[0] = if0.prdata;  assign rdy[0] = if0.pready;  assign err[0] = if0.pslverr;  assign sel[0] = if0.psel;
    assign prd[1] = if1.prdata;  assign rdy[1] = if1.pready;  assign err[1] = if1.pslverr;  assign sel[1] = if1.psel;
    assign prd[2] = if2.prdata;  assign rdy[2] = if2.pready;  assign err[2] = if2.pslverr;  assign sel[2] = if2.psel;

    // ---------------- behavioural model ----------------
    int          wc [3] = '{0, 1, 7};
    logic [31:0] mregs [3][NR];
    logic [31:0] exp_prdata [3];
    int          cur_k     = -1;
    logic        cur_wr    = 1'b0;
    logic [4:0]  cur_addr  = '0;
    logic [31:0] cur_data  = '0;
    int          acc_cycle = 0;

    int          run [3];
    int          last_len [3];
    logic [31:0] last_prdata [3];
    logic        last_err [3];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, actual, required, $time);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < 3; j++) begin
            for (int r = 0; r < NR; r++) mregs[j][r] = '0;
            exp_prdata[j] = '0;
            run[j]        = 0;
        end
    endtask

    // Response of completer j to the transfer now finishing, from the register-map rules.
    task automatic model_commit(input int j, output logic [31:0] p, output logic e);
        p = exp_prdata[j];
        e = 1'b0;
        if (int'(cur_addr) < NR) begin
            if (cur_wr) mregs[j][cur_addr[3:0]] = cur_data;
            else        p = mregs[j][cur_addr[3:0]];
        end else if ((cur_addr == APB_ID_ADDR) && !cur_wr) begin
            p = APB_ID_VALUE;
        end else begin
            p = '0;
            e = 1'b1;
        end
        exp_prdata[j] = p;
    endtask

    // ---------------- compare process ----------------
    logic        e_rdy;
    logic [31:0] e_p;
    logic        e_e;
    always @(negedge clk) begin
        for (int j = 0; j < 3; j++) begin
            if (!rst_n) begin
                chk($sformatf("rst_pready%0d", j),  32'(rdy[j]), 32'd0);
                chk($sformatf("rst_prdata%0d", j),  prd[j],      32'd0);
                chk($sformatf("rst_pslverr%0d", j), 32'(err[j]), 32'd0);
            end else begin
                e_rdy = (cur_k == j) && (acc_cycle == wc[j] + 2);
                e_p   = exp_prdata[j];
                e_e   = 1'b0;
                if (e_rdy) model_commit(j, e_p, e_e);
                chk($sformatf("pready%0d", j),  32'(rdy[j]), 32'(e_rdy));
                chk($sformatf("prdata%0d", j),  prd[j],      e_p);
                chk($sformatf("pslverr%0d", j), 32'(err[j]), 32'(e_e));
                if (!sel[j] || (!penable && !rdy[j])) run[j] = 0;
                else                                   run[j]++;
                if (rdy[j]) begin
                    last_len[j]    = run[j];
                    last_prdata[j] = prd[j];
                    last_err[j]    = err[j];
                    run[j]         = 0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic xfer(input int k, input logic wr, input logic [4:0] addr, input logic [31:0] data,
                        input int extra_setup, input int abort_at, input logic from_b2b, input logic to_b2b);
        if (!from_b2b) begin
            @(posedge clk); #1;
            act = k; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
        end
        repeat (extra_setup) begin
            @(posedge clk); #1;
            penable = 1'b0; acc_cycle = 0;
        end
        for (int a = 1; a <= wc[k] + 2; a++) begin
            @(posedge clk); #1;
            if (a == abort_at) begin
                psel = 1'b0; penable = 1'b0; acc_cycle = 0;
                return;
            end
            if (a == 1) begin
                cur_k = k; cur_wr = wr; cur_addr = addr; cur_data = data;
            end
            penable = 1'b1; pwrite = wr; acc_cycle = a;
            if (a <= wc[k]) begin
                paddr  = 5'($urandom);
                pwdata = $urandom;
            end else begin
                paddr  = addr;
                pwdata = data;
            end
            if ((a == wc[k] + 2) && to_b2b) penable = 1'b0;
        end
        if (!to_b2b) begin
            @(posedge clk); #1;
            psel = 1'b0; penable = 1'b0; acc_cycle = 0;
        end
    endtask

    task automatic dxfer(input int k, input logic wr, input logic [4:0] addr, input logic [31:0] data);
        last_len[k]    = -1;
        last_prdata[k] = 'x;
        last_err[k]    = 1'bx;
        xfer(k, wr, addr, data, 0, 0, 1'b0, 1'b0);
    endtask

    // ---------------- main sequence ----------------
    logic        b2b;
    logic        nb;
    logic        rwr;
    logic [4:0]  rad;
    int          rk;
    int          rab;
    int          rsel;

    initial begin
        model_reset();
        for (int j = 0; j < 3; j++) begin
            last_len[j] = -1; last_prdata[j] = '0; last_err[j] = 1'b0;
        end
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk); #1;
        for (int j = 0; j < 3; j++) chk($sformatf("reset_state%0d", j), 32'(dbg[j]), 32'(IDLE));

        // Register write/read with one wait state.
        dxfer(1, 1'b1, 5'd3, 32'hDEAD_BEEF);
        chk("wr3_err", 32'(last_err[1]), 32'd0);
        chk("wr3_len", 32'(last_len[1]), 32'd3);
        dxfer(1, 1'b0, 5'd3, 32'h0);
        chk("rd3_data", last_prdata[1], 32'hDEAD_BEEF);
        chk("rd3_err",  32'(last_err[1]), 32'd0);
        chk("rd3_len",  32'(last_len[1]), 32'd3);

        // ID register.
        dxfer(1, 1'b0, 5'h1F, 32'h0);
        chk("rd_id_data", last_prdata[1], 32'hA9B0_0001);
        chk("rd_id_err",  32'(last_err[1]), 32'd0);
        dxfer(1, 1'b1, 5'h1F, 32'h1234);
        chk("wr_id_err",  32'(last_err[1]), 32'd1);
        chk("wr_id_data", last_prdata[1], 32'd0);
        dxfer(1, 1'b0, 5'h1F, 32'h0);
        chk("rerd_id_data", last_prdata[1], 32'hA9B0_0001);

        // Unmapped addresses.
        dxfer(1, 1'b0, 5'h10, 32'h0);
        chk("rd10_data", last_prdata[1], 32'd0);
        chk("rd10_err",  32'(last_err[1]), 32'd1);
        dxfer(1, 1'b1, 5'h14, 32'hFFFF_FFFF);
        chk("wr14_err",  32'(last_err[1]), 32'd1);
        for (int r = 0; r < NR; r++) begin
            dxfer(1, 1'b0, 5'(r), 32'h0);
            chk($sformatf("after_wr14_reg%0d", r), last_prdata[1], (r == 3) ? 32'hDEAD_BEEF : 32'd0);
        end

        // ACCESS length for 0 and 7 wait states.
        dxfer(0, 1'b1, 5'd5, 32'h77);
        chk("len_w0", 32'(last_len[0]), 32'd2);
        dxfer(2, 1'b0, 5'd5, 32'h0);
        chk("len_w7",  32'(last_len[2]), 32'd9);
        chk("w7_data", last_prdata[2], 32'd0);

        // Back-to-back write then read, no IDLE gap.
        last_len[1] = -1; last_prdata[1] = 'x;
        xfer(1, 1'b1, 5'd0, 32'h1, 0, 0, 1'b0, 1'b1);
        xfer(1, 1'b0, 5'd0, 32'h0, 0, 0, 1'b1, 1'b0);
        chk("b2b_data", last_prdata[1], 32'h1);
        chk("b2b_len",  32'(last_len[1]), 32'd3);

        // Randomized traffic.
        b2b = 1'b0;
        rk  = 1;
        for (int n = 0; n < 300; n++) begin
            if (!b2b) rk = $urandom_range(0, 2);
            rwr  = 1'($urandom_range(0, 1));
            rsel = $urandom_range(0, 9);
            if (rsel < 6)      rad = 5'($urandom_range(0, 15));
            else if (rsel < 8) rad = 5'h1F;
            else               rad = 5'($urandom_range(16, 30));
            rab = ($urandom_range(0, 9) == 0) ? $urandom_range(1, wc[rk] + 1) : 0;
            nb  = (rab == 0) && (n != 299) && ($urandom_range(0, 3) == 0);
            if (!b2b && ($urandom_range(0, 15) == 0)) begin
                @(posedge clk); #1;
                act = rk; psel = 1'b1; penable = 1'b1;
            end
            xfer(rk, rwr, rad, $urandom, b2b ? 0 : $urandom_range(0, 1), rab, b2b, nb);
            b2b = nb;
        end

        // Reset in the middle of a write.
        dxfer(1, 1'b1, 5'd3, 32'hCAFE_F00D);
        dxfer(1, 1'b0, 5'd3, 32'h0);
        chk("pre_rst_data", last_prdata[1], 32'hCAFE_F00D);
        @(posedge clk); #1;
        act = 1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 5'd2; pwdata = 32'h55;
        @(posedge clk); #1;
        penable = 1'b1;
        #2;
        rst_n = 1'b0;
        acc_cycle = 0;
        model_reset();
        #1;
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("async_rst_prdata%0d", j),  prd[j],      32'd0);
            chk($sformatf("async_rst_pready%0d", j),  32'(rdy[j]), 32'd0);
            chk($sformatf("async_rst_pslverr%0d", j), 32'(err[j]), 32'd0);
            chk($sformatf("async_rst_state%0d", j),   32'(dbg[j]), 32'(IDLE));
        end
        psel = 1'b0; penable = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        dxfer(1, 1'b0, 5'd2, 32'h0);
        chk("post_rst_rd2", last_prdata[1], 32'd0);
        chk("post_rst_err", 32'(last_err[1]), 32'd0);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_slave_regfile.md
Name: apb_slave_regfile

Overview:
- APB completer (slave) that sits directly downstream of the team's APB requester FSM and consumes its psel/penable/pwrite/paddr/pwdata outputs.
- Returns pready, prdata and pslverr to that requester.
- Contains a small word-addressed register file and a programmable wait-state counter, so the requester's ACCESS and WAIT states can both be exercised.
- Out-of-range or illegal accesses complete normally with pslverr=1.

Parameters:
- ADDR_W, 5, paddr width; word index; no byte lanes.
- DATA_W, 32, data width.
- NUM_REGS, 16, number of RW registers at addresses 0..NUM_REGS-1; must be at most 2^ADDR_W-1.
- WAIT_CYCLES, 1, extra ACCESS cycles inserted before pready asserts; 0..15.
- ID_VALUE, 32'hA9B0_0001, constant returned by the read-only ID register at address 2^ADDR_W-1 (5'h1F).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- psel  in  1  select from the requester.
- penable  in  1  ACCESS-phase indicator.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_W  word address.
- pwdata  in  DATA_W  write data.
- prdata  out  DATA_W  read data; registered.
- pready  out  1  transfer completion; registered.
- pslverr  out  1  error response, valid only while pready=1; registered.

Behaviour:
- Reset: already decided; reset rst_n, asynchronous, active-low; clock clk.
- Reset values: state=IDLE, wait counter=0, prdata=0, pready=0, pslverr=0, all registers=0.
- Reset asserted mid-transfer aborts the transfer immediately. A write that has not yet committed is lost.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - pready=0.
  - On an edge sampling psel=1 & penable=0 (SETUP): load cnt<=WAIT_CYCLES, go to WAIT.
  - psel=1 & penable=1 sampled in IDLE is a protocol violation: ignore it and stay in IDLE.
- WAIT:
  - psel=0 sampled: abort, go to IDLE, no register update, no response.
  - psel=1 & penable=1 & cnt!=0: cnt<=cnt-1.
  - psel=1 & penable=1 & cnt==0: commit, pready<=1, go to RESP.
  - psel=1 & penable=0: hold (still SETUP).
- Commit, performed at the edge entering RESP:
  - Write to addr < NUM_REGS: regs[addr]<=pwdata, pslverr<=0.
  - Read from addr < NUM_REGS: prdata<=regs[addr], pslverr<=0.
  - Read from 5'h1F: prdata<=ID_VALUE, pslverr<=0.
  - Write to 5'h1F, or any access to NUM_REGS <= addr < 5'h1F: no register change, prdata<=0, pslverr<=1.
  - After a write, prdata keeps its previous value.
- RESP:
  - pready=1 for exactly one cycle; the transfer completes at the next edge.
  - At that edge: pready<=0, pslverr<=0.
  - If psel=1 & penable=0 is sampled at that edge (back-to-back SETUP): reload cnt and go to WAIT. Otherwise go to IDLE.
- Latency: ACCESS phase lasts WAIT_CYCLES+2 cycles, measured from the first cycle penable=1 to the completion edge inclusive. Example: WAIT_CYCLES=0 gives 2 cycles.
- Simultaneous events: address and data are sampled only at the commit edge; changes earlier in ACCESS are ignored.
- No combinational path from any input to any output.

Decomposition:
- Package apb_pkg holds:
  - the state enum (IDLE/WAIT/RESP);
  - APB_ADDR_W=5 and APB_DATA_W=32;
  - APB_ID_ADDR=5'h1F;
  - the default ID_VALUE constant.
- Natural sub-module: apb_regfile_mem, the NUM_REGS x DATA_W array.
  - Async clear on rst_n.
  - Single write port (we, waddr, wdata).
  - Single combinational read port (raddr → rdata).
- apb_slave_regfile keeps the FSM, wait counter, address decode and response registers.

Test Plan:
- WAIT_CYCLES=1; write 32'hDEAD_BEEF to addr 3, then read addr 3 → pready high in the 3rd ACCESS cycle each time, prdata=32'hDEAD_BEEF, pslverr=0.
- Read 5'h1F → prdata=32'hA9B0_0001, pslverr=0. Write 5'h1F with 32'h1234 → pslverr=1, then a re-read still returns the ID value.
- Read addr 5'h10 (NUM_REGS=16) → prdata=0, pslverr=1. Write 5'h14 → pslverr=1, and all regs 0..15 are unchanged.
- WAIT_CYCLES=0 vs 7: measure ACCESS-phase length → 2 and 9 cycles. pready is high for exactly one cycle each time.
- Back-to-back: write addr 0 = 32'h1, SETUP of read addr 0 in the completion cycle → second transfer accepted with no IDLE gap, prdata=32'h1.
- Assert rst_n low in WAIT during a write of 32'h55 to addr 2 → outputs 0 within the same cycle. After release, read addr 2 → 0.
